// File: rtl/sccb_pkg.sv
// Shared SCCB encodings: table ops, sequencer states, bridge command/response
// codes and error codes, plus a small counter-load helper.
package sccb_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_ISSUE     = 4'd3,
    S_WAIT_RESP = 4'd4,
    S_WAIT_IDLE = 4'd5,
    S_DELAY     = 4'd6,
    S_DONE      = 4'd7,
    S_ERROR     = 4'd8
  } state_e;

  localparam logic [2:0] MCMD_IDLE = 3'b000;
  localparam logic [2:0] MCMD_WR   = 3'b001;
  localparam logic [2:0] MCMD_RD   = 3'b010;

  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // A down-counter that stops at zero spends n cycles when loaded with n-1;
  // a request of zero cycles still costs one.
  function automatic logic [31:0] cycles_to_load(input logic [31:0] n);
    return (n == 32'd0) ? 32'd0 : n - 32'd1;
  endfunction

endpackage

// File: rtl/sccb_tick_cnt.sv
// Loadable down-counter that saturates at zero; tc is high while the count is zero.
module sccb_tick_cnt
  import sccb_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: load wins over decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (enable && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/sccb_init_seq.sv
// Table-driven SCCB init sequencer: fetches 24-bit entries and turns them into
// bridge writes, read-checks and delays, with a per-transaction watchdog.
module sccb_init_seq
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ID   = 7'h21,
  parameter int          TBL_AW   = 8,
  parameter logic [15:0] DLY_UNIT = 16'd1000,
  parameter logic [19:0] TMO      = 20'hFFFFF
) (
  input  logic              sccb_clk,
  input  logic              sccb_reset,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic [2:0]        mcmd,
  output logic [14:0]       maddr,
  output logic [7:0]        mdata,
  input  logic              scmdaccept,
  input  logic [1:0]        sresp,
  input  logic [7:0]        sdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] err_index,
  output logic [1:0]        err_code
);

  state_e            state_q, state_d;
  logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
  logic [2:0]        mcmd_q, mcmd_d;
  logic [14:0]       maddr_q, maddr_d;
  logic [7:0]        mdata_q, mdata_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [TBL_AW-1:0] err_index_q, err_index_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              cnt_load_s, cnt_en_s, cnt_tc_s;
  logic [31:0]       cnt_val_s;
  logic              adv_s, fail_s;
  logic [1:0]        fail_code_s;
  logic [TBL_AW:0]   addr_nxt_s;
  logic [31:0]       dly_cycles_s;
  logic              rsvd_unused;

  assign addr_nxt_s   = {1'b0, tbl_addr_q} + {{TBL_AW{1'b0}}, 1'b1};
  assign dly_cycles_s = {16'd0, tbl_data[15:0]} * {16'd0, DLY_UNIT};
  assign rsvd_unused  = ^tbl_data[21:16];

  // Delay timer and transaction watchdog never run together, so they share one counter.
  sccb_tick_cnt #(.W(32)) u_tick (
    .clk      (sccb_clk),
    .rst      (sccb_reset),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .enable   (cnt_en_s),
    .tc       (cnt_tc_s)
  );

  // next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    tbl_addr_d  = tbl_addr_q;
    mcmd_d      = mcmd_q;
    maddr_d     = maddr_q;
    mdata_d     = mdata_q;
    err_index_d = err_index_q;
    err_code_d  = err_code_q;
    cnt_load_s  = 1'b0;
    cnt_val_s   = 32'd0;
    cnt_en_s    = 1'b0;
    adv_s       = 1'b0;
    fail_s      = 1'b0;
    fail_code_s = ERR_NONE;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_FETCH;
          tbl_addr_d  = {TBL_AW{1'b0}};
          err_index_d = {TBL_AW{1'b0}};
          err_code_d  = ERR_NONE;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op_e'(tbl_data[23:22]))
          OP_WRITE, OP_READ: begin
            state_d    = S_ISSUE;
            mcmd_d     = (tbl_data[23:22] == OP_READ) ? MCMD_RD : MCMD_WR;
            maddr_d    = {DEV_ID, tbl_data[15:8]};
            mdata_d    = tbl_data[7:0];
            cnt_load_s = 1'b1;
            cnt_val_s  = cycles_to_load({12'd0, TMO});
          end
          OP_DELAY: begin
            state_d    = S_DELAY;
            cnt_load_s = 1'b1;
            cnt_val_s  = cycles_to_load(dly_cycles_s);
          end
          OP_END:  state_d = S_DONE;
          default: state_d = S_DONE;
        endcase
      end
      S_ISSUE: begin
        cnt_en_s = 1'b1;
        if (scmdaccept) begin
          state_d = S_WAIT_RESP;
        end else if (cnt_tc_s) begin
          fail_s      = 1'b1;
          fail_code_s = ERR_TIMEOUT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_RESP: begin
        cnt_en_s = 1'b1;
        // Only the first DVA cycle is consumed; WAIT_IDLE swallows the rest.
        if (sresp == SRESP_DVA) begin
          mcmd_d = MCMD_IDLE;
          if ((mcmd_q == MCMD_RD) && (sdata != mdata_q)) begin
            fail_s      = 1'b1;
            fail_code_s = ERR_MISMATCH;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end else if (cnt_tc_s) begin
          fail_s      = 1'b1;
          fail_code_s = ERR_TIMEOUT;
        end else begin
          state_d = S_WAIT_RESP;
        end
      end
      S_WAIT_IDLE: begin
        cnt_en_s = 1'b1;
        if ((sresp == SRESP_NULL) && scmdaccept) begin
          adv_s = 1'b1;
        end else if (cnt_tc_s) begin
          fail_s      = 1'b1;
          fail_code_s = ERR_TIMEOUT;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_DELAY: begin
        if (cnt_tc_s) begin
          adv_s = 1'b1;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Running off the end of the table finishes the run instead of wrapping.
    if (adv_s) begin
      if (addr_nxt_s[TBL_AW]) begin
        state_d = S_DONE;
      end else begin
        state_d    = S_FETCH;
        tbl_addr_d = addr_nxt_s[TBL_AW-1:0];
      end
    end else begin
      tbl_addr_d = tbl_addr_d;
    end

    if (fail_s) begin
      state_d     = S_ERROR;
      err_code_d  = fail_code_s;
      err_index_d = tbl_addr_q;
      mcmd_d      = MCMD_IDLE;
    end else begin
      err_code_d = err_code_d;
    end

    busy_d  = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  // state and output registers
  always_ff @(posedge sccb_clk) begin
    if (sccb_reset) begin
      state_q     <= S_IDLE;
      tbl_addr_q  <= {TBL_AW{1'b0}};
      mcmd_q      <= MCMD_IDLE;
      maddr_q     <= 15'd0;
      mdata_q     <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= {TBL_AW{1'b0}};
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      tbl_addr_q  <= tbl_addr_d;
      mcmd_q      <= mcmd_d;
      maddr_q     <= maddr_d;
      mdata_q     <= mdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      err_code_q  <= err_code_d;
    end
  end

  assign tbl_addr  = tbl_addr_q;
  assign mcmd      = mcmd_q;
  assign maddr     = maddr_q;
  assign mdata     = mdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Directed bench for sccb_init_seq with a small table ROM and SCCB bridge model.
module tb_sccb_init_seq;

  localparam int TBL_AW = 2;

  logic              sccb_clk = 1'b0;
  logic              sccb_reset = 1'b1;
  logic              start = 1'b0;
  logic [TBL_AW-1:0] tbl_addr;
  logic [23:0]       tbl_data = 24'h0;
  logic [2:0]        mcmd;
  logic [14:0]       maddr;
  logic [7:0]        mdata;
  logic              scmdaccept = 1'b0;
  logic [1:0]        sresp = 2'b00;
  logic [7:0]        sdata = 8'h00;
  logic              busy, done, error;
  logic [TBL_AW-1:0] err_index;
  logic [1:0]        err_code;

  logic [23:0] tbl [4];
  logic        bridge_en = 1'b1;
  logic [7:0]  rd_data = 8'h00;
  int          n_txn = 0;
  logic [2:0]  last_mcmd = 3'b000;
  logic [14:0] last_maddr = 15'h0;
  logic [7:0]  last_mdata = 8'h0;
  int          n_checks = 0;
  int          n_err = 0;

  sccb_init_seq #(
    .DEV_ID   (7'h21),
    .TBL_AW   (TBL_AW),
    .DLY_UNIT (16'd4),
    .TMO      (20'd100)
  ) dut (
    .sccb_clk   (sccb_clk),
    .sccb_reset (sccb_reset),
    .start      (start),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .mcmd       (mcmd),
    .maddr      (maddr),
    .mdata      (mdata),
    .scmdaccept (scmdaccept),
    .sresp      (sresp),
    .sdata      (sdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_index  (err_index),
    .err_code   (err_code)
  );

  always #5 sccb_clk = ~sccb_clk;

  // Table ROM (one-cycle latency) and bridge: accept, 2-cycle gap, DVA held 4 cycles.
  initial begin : bridge_model
    int ph;
    ph = 0;
    forever begin
      @(posedge sccb_clk);
      #2;
      tbl_data = tbl[tbl_addr];
      if (sccb_reset || !bridge_en) begin
        ph = 0;
        scmdaccept = bridge_en;
        sresp = 2'b00;
      end else begin
        case (ph)
          0: begin
            scmdaccept = 1'b1;
            sresp = 2'b00;
            if (mcmd != 3'b000) begin
              n_txn++;
              last_mcmd = mcmd;
              last_maddr = maddr;
              last_mdata = mdata;
              ph = 1;
            end
          end
          1: begin
            scmdaccept = 1'b0;
            ph = 2;
          end
          2, 3, 4, 5: begin
            sresp = 2'b01;
            sdata = rd_data;
            ph++;
          end
          default: begin
            sresp = 2'b00;
            sdata = 8'h00;
            scmdaccept = 1'b1;
            ph = 0;
          end
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge sccb_clk);
    start = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge sccb_clk);
      n++;
    end
    check({tag, "_bound"}, 32'(n < 400), 32'd1);
  endtask

  initial begin : stim
    int n0;
    int n;
    logic wrapped;
    logic [TBL_AW-1:0] prev_addr;

    for (int i = 0; i < 4; i++) tbl[i] = 24'hC00000;
    repeat (3) @(negedge sccb_clk);
    check("rst_mcmd", 32'(mcmd), 32'h0);
    check("rst_maddr", 32'(maddr), 32'h0);
    check("rst_mdata", 32'(mdata), 32'h0);
    check("rst_addr", 32'(tbl_addr), 32'h0);
    check("rst_status", 32'({busy, done, error}), 32'h0);
    check("rst_err", 32'({err_index, err_code}), 32'h0);
    sccb_reset = 1'b0;
    repeat (3) @(negedge sccb_clk);

    // single write then end
    tbl[0] = 24'h001280;
    tbl[1] = 24'hC00000;
    n0 = n_txn;
    pulse_start();
    wait_not_busy("wr");
    check("wr_ntxn", 32'(n_txn - n0), 32'd1);
    check("wr_mcmd", 32'(last_mcmd), 32'h1);
    check("wr_maddr", 32'(last_maddr), 32'h2112);
    check("wr_mdata", 32'(last_mdata), 32'h80);
    check("wr_done", 32'({busy, done, error}), 32'b010);
    repeat (10) @(negedge sccb_clk);

    // read-check that matches
    tbl[0] = 24'h400A76;
    rd_data = 8'h76;
    pulse_start();
    wait_not_busy("rdok");
    check("rdok_mcmd", 32'(last_mcmd), 32'h2);
    check("rdok_maddr", 32'(last_maddr), 32'h210A);
    check("rdok_done", 32'({done, error}), 32'b10);
    repeat (10) @(negedge sccb_clk);

    // read-check that mismatches
    rd_data = 8'h73;
    pulse_start();
    wait_not_busy("rdbad");
    check("rdbad_status", 32'({done, error}), 32'b01);
    check("rdbad_code", 32'(err_code), 32'h1);
    check("rdbad_index", 32'(err_index), 32'h0);
    check("rdbad_mcmd", 32'(mcmd), 32'h0);
    repeat (10) @(negedge sccb_clk);

    // delay of 3 ticks x 4 cycles: FETCH + DECODE + 12 DELAY cycles at index 0
    tbl[0] = 24'h800003;
    n0 = n_txn;
    pulse_start();
    n = 0;
    while (busy && tbl_addr == 2'd0 && n < 100) begin
      @(negedge sccb_clk);
      n++;
    end
    check("dly_cycles", 32'(n), 32'd14);
    check("dly_next_addr", 32'(tbl_addr), 32'h1);
    wait_not_busy("dly");
    check("dly_done", 32'({done, error, err_code}), 32'b1000);
    check("dly_ntxn", 32'(n_txn - n0), 32'd0);
    repeat (10) @(negedge sccb_clk);

    // watchdog: bridge never accepts
    tbl[0] = 24'h001280;
    bridge_en = 1'b0;
    repeat (2) @(negedge sccb_clk);
    pulse_start();
    n = 0;
    while (mcmd == 3'b000 && n < 20) begin
      @(negedge sccb_clk);
      n++;
    end
    check("tmo_issue_bound", 32'(n < 20), 32'd1);
    n = 0;
    while (!error && n < 300) begin
      n++;
      @(negedge sccb_clk);
    end
    check("tmo_cycles", 32'(n), 32'd100);
    check("tmo_code", 32'(err_code), 32'h2);
    check("tmo_mcmd", 32'(mcmd), 32'h0);
    check("tmo_status", 32'({busy, done, err_index}), 32'h0);
    bridge_en = 1'b1;
    repeat (10) @(negedge sccb_clk);

    // reset while waiting for the response
    n0 = n_txn;
    pulse_start();
    n = 0;
    while (n_txn == n0 && n < 50) begin
      @(negedge sccb_clk);
      n++;
    end
    check("rstmid_txn_bound", 32'(n < 50), 32'd1);
    @(negedge sccb_clk);
    check("rstmid_held", 32'({mcmd, maddr}), {14'd0, 3'b001, 15'h2112});
    sccb_reset = 1'b1;
    @(negedge sccb_clk);
    check("rstmid_mcmd", 32'(mcmd), 32'h0);
    check("rstmid_status", 32'({busy, done, error}), 32'h0);
    sccb_reset = 1'b0;
    repeat (3) @(negedge sccb_clk);
    n0 = n_txn;
    pulse_start();
    check("rerun_addr", 32'({busy, tbl_addr}), 32'b100);
    wait_not_busy("rerun");
    check("rerun_ntxn", 32'(n_txn - n0), 32'd1);
    check("rerun_done", 32'({done, error}), 32'b10);
    repeat (10) @(negedge sccb_clk);

    // full table of writes, no end entry
    tbl[0] = 24'h000101;
    tbl[1] = 24'h000202;
    tbl[2] = 24'h000303;
    tbl[3] = 24'h000404;
    n0 = n_txn;
    wrapped = 1'b0;
    pulse_start();
    prev_addr = tbl_addr;
    n = 0;
    while (busy && n < 400) begin
      @(negedge sccb_clk);
      if (prev_addr == 2'd3 && tbl_addr == 2'd0) wrapped = 1'b1;
      prev_addr = tbl_addr;
      n++;
    end
    check("full_bound", 32'(n < 400), 32'd1);
    check("full_ntxn", 32'(n_txn - n0), 32'd4);
    check("full_last_maddr", 32'(last_maddr), 32'h2104);
    check("full_done", 32'({done, error}), 32'b10);
    check("full_addr", 32'(tbl_addr), 32'h3);
    check("full_nowrap", 32'(wrapped), 32'd0);
    repeat (20) @(negedge sccb_clk);
    check("full_no_fifth", 32'(n_txn - n0), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sccb_init_seq.md
SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

Interface
REQ-001 SHALL have parameter DEV_ID, default 7'h21, the 7-bit SCCB device ID placed on maddr[14:8].
REQ-002 SHALL have parameter TBL_AW, default 8, the table address width.
REQ-003 SHALL have parameter DLY_UNIT, default 16'd1000, the sccb_clk cycles per delay tick.
REQ-004 SHALL have parameter TMO, default 20'hFFFFF, the per-transaction timeout in sccb_clk cycles.
REQ-005 SHALL have port sccb_clk, input, 1, the single clock; the block uses one clock, rising edge only.
REQ-006 SHALL have port sccb_reset, input, 1, a synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, a pulse that begins a table run.
REQ-008 SHALL have port tbl_addr, output, TBL_AW, the table read address.
REQ-009 SHALL have port tbl_data, input, 24, the table entry, valid 1 cycle after tbl_addr.
REQ-010 SHALL have ports mcmd (output, 3), maddr (output, 15) and mdata (output, 8) as the bridge command bus; mcmd is 000 idle, 001 write, 010 read.
REQ-011 SHALL have ports scmdaccept (input, 1), sresp (input, 2, 01=DVA) and sdata (input, 8) as the bridge response bus.
REQ-012 SHALL have ports busy, done and error, each output, 1, as status levels.
REQ-013 SHALL have port err_index, output, TBL_AW, the table index of the first failure.
REQ-014 SHALL have port err_code, output, 2: 01 mismatch, 10 timeout.

Function
REQ-015 SHALL decode each entry as op[23:22], reserved[21:16], reg[15:8], val[7:0]; op 00 write, 01 read-check, 10 delay, 11 end.
REQ-016 SHALL implement the states IDLE, FETCH, DECODE, ISSUE, WAIT_RESP, WAIT_IDLE, DELAY, DONE, ERROR.
REQ-017 SHALL move IDLE->FETCH on start, clearing done/error/err_index/err_code and setting tbl_addr=0; start is ignored outside IDLE/DONE/ERROR.
REQ-018 SHALL use two cycles per fetch: FETCH drives tbl_addr, DECODE samples tbl_data.
REQ-019 SHALL move DECODE to ISSUE for op 00/01, to DELAY for op 10, and to DONE for op 11.
REQ-020 SHALL move to DONE, without fetching, when tbl_addr wraps past 2^TBL_AW-1.
REQ-021 SHALL in ISSUE drive mcmd=001 (op 00) or 010 (op 01), maddr={DEV_ID,reg}, mdata=val, and go to WAIT_RESP when scmdaccept=1.
REQ-022 SHALL hold mcmd/maddr/mdata stable from ISSUE until the first cycle with sresp==01, then drive mcmd=000 in the next cycle.
REQ-023 SHALL consume only the first sresp==01 cycle per transaction, since DVA persists for several sccb_clk cycles.
REQ-024 SHALL for a read-check compare sdata to val in the DVA cycle; a mismatch enters ERROR with err_code=01.
REQ-025 SHALL in WAIT_IDLE wait until sresp==00 and scmdaccept==1, then increment tbl_addr and go to FETCH.
REQ-026 SHALL in DELAY wait {reg,val} x DLY_UNIT cycles; a count of 0 SHALL take 1 cycle; then increment tbl_addr.
REQ-027 SHALL run a 20-bit watchdog, cleared on entering ISSUE, active in ISSUE, WAIT_RESP and WAIT_IDLE; reaching TMO enters ERROR with err_code=10.
REQ-028 SHALL on entering ERROR latch err_index=tbl_addr and drive mcmd=000.
REQ-029 SHALL drive busy=1 in all states except IDLE, DONE and ERROR; done=1 only in DONE; error=1 only in ERROR.
REQ-030 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-031 SHALL on sccb_reset=1 at a clock edge force state IDLE, mcmd=000, maddr=0, mdata=0, tbl_addr=0, busy/done/error=0, err_index=0, err_code=00 and clear all counters.
REQ-032 SHALL on reset mid-transaction drop mcmd at once; bridge recovery is the bridge's own reset's concern.

Structure
REQ-033 SHALL place the op encodings, state encodings, err_code values and the mcmd/sresp encodings in shared package sccb_pkg, used by the bridge-side blocks too.
REQ-034 SHALL implement the delay/watchdog counter as one sub-module, sccb_tick_cnt (load, enable, terminal-count output).

Verification
REQ-035 SHALL cover this scenario: a table of {00,.,12,80},{11} with a bridge model giving DVA for 4 cycles -> exactly one mcmd=001 with maddr=15'h2112 and mdata=80, then done=1 with busy=0.
REQ-036 SHALL cover this scenario: a read-check {01,.,0A,76} with sdata=76 -> done=1; with sdata=73 -> error=1, err_code=01, err_index=0.
REQ-037 SHALL cover this scenario: delay {10,.,00,03} with DLY_UNIT=4 -> 12 cycles in DELAY (±1 documented), then fetch index 1.
REQ-038 SHALL cover this scenario: scmdaccept held 0 with TMO=100 -> error=1, err_code=10 after 100 cycles and mcmd=000.
REQ-039 SHALL cover this scenario: sccb_reset asserted in WAIT_RESP -> next cycle mcmd=000, busy=0, and a following start reruns from index 0.
REQ-040 SHALL cover this scenario: TBL_AW=2 with a table holding no end entry -> 4 transactions, then done=1 with no fifth fetch.
